// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared types, widths and frame helper for the SPI master controller
//  Purpose: command/state encodings and the frame-word builder used by spi_master_ctrl.
package shared_pkg;

    localparam int SPI_FRAME_W = 10;
    localparam int SPI_DATA_W  = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        M_IDLE,
        M_CMD,
        M_SHIFT,
        M_TURN,
        M_RECV,
        M_GAP
    } spi_mstate_e;

    // Read-data carries no payload; zeros go out so the slave sees a clean frame.
    function automatic logic [SPI_FRAME_W-1:0] spi_frame_word(
        input logic [1:0]            op,
        input logic [SPI_DATA_W-1:0] data
    );
        return {op, (op == RD_DATA) ? {SPI_DATA_W{1'b0}} : data};
    endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// rtl/spi_master_shreg.sv - frame shift-out and reply shift-in registers for the SPI master
//  Purpose: holds the outgoing frame word and collects the incoming MISO byte.
//  Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_word (start of frame), clears the receive bits
//   load_word    10-bit frame word {op, payload}
//   shift_out    advance the frame word by one bit (MSB first)
//   shift_in     append miso to the receive bits
//   miso         serial input from the slave
//   tx_bit       current frame MSB
//   rx_next      receive byte including the miso bit of this cycle
module spi_master_shreg
    import shared_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [SPI_FRAME_W-1:0] load_word,
    input  logic                   shift_out,
    input  logic                   shift_in,
    input  logic                   miso,
    output logic                   tx_bit,
    output logic [SPI_DATA_W-1:0]  rx_next
);

    logic [SPI_FRAME_W-1:0] tx_q;
    // Only seven received bits need storing: the eighth comes straight from
    // miso on the final sample, so rx_next is the complete byte at that edge.
    logic [SPI_DATA_W-2:0]  rx_q;

    assign tx_bit  = tx_q[SPI_FRAME_W-1];
    assign rx_next = {rx_q, miso};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load) begin
                tx_q <= load_word;
            end else if (shift_out) begin
                tx_q <= {tx_q[SPI_FRAME_W-2:0], 1'b0};
            end
            if (load) begin
                rx_q <= '0;
            end else if (shift_in) begin
                rx_q <= rx_next[SPI_DATA_W-2:0];
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - host-side SPI master serialising command frames and collecting read replies
//  Purpose: accepts {cmd_op, cmd_data} requests, drives SS_n/MOSI frames, returns read-data bytes.
//  Parameters: TURN_CYCLES (1..16) turnaround before MISO sampling, GAP_CYCLES (1..16) SS_n high time.
//  Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    request handshake; ready only while idle
//   cmd_op, cmd_data       2-bit command and 8-bit payload
//   resp_valid, resp_data  one-cycle pulse with the received read-data byte
//   busy                   frame or inter-frame gap in progress
//   SS_n, MOSI, MISO       SPI slave select, serial out, serial in (MSB first)
module spi_master_ctrl
    import shared_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] SHIFT_LAST = 4'(SPI_FRAME_W - 1);
    localparam logic [3:0] RECV_LAST  = 4'(SPI_DATA_W - 1);
    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    spi_mstate_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            op_q;
    logic                  accept;
    logic                  shift_out;
    logic                  shift_in;
    logic                  tx_bit;
    logic [SPI_DATA_W-1:0] rx_next;
    logic                  ss_n_d;
    logic                  mosi_d;
    logic                  resp_valid_d;

    assign accept    = cmd_valid && cmd_ready;
    // The CMD cycle repeats W[9], so the first shift happens leaving CMD;
    // the last SHIFT cycle has nothing left to advance.
    assign shift_out = (state_q == M_CMD) || ((state_q == M_SHIFT) && (cnt_q != SHIFT_LAST));
    assign shift_in  = (state_q == M_RECV);

    spi_master_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_word (spi_frame_word(cmd_op, cmd_data)),
        .shift_out (shift_out),
        .shift_in  (shift_in),
        .miso      (MISO),
        .tx_bit    (tx_bit),
        .rx_next   (rx_next)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = 4'd0;
        ss_n_d       = 1'b1;
        mosi_d       = 1'b0;
        resp_valid_d = 1'b0;

        case (state_q)
            M_IDLE:  if (accept) state_d = M_CMD;
            M_CMD:   state_d = M_SHIFT;
            M_SHIFT: if (cnt_q == SHIFT_LAST) state_d = (op_q == RD_DATA) ? M_TURN : M_GAP;
            M_TURN:  if (cnt_q == TURN_LAST) state_d = M_RECV;
            M_RECV:  if (cnt_q == RECV_LAST) state_d = M_GAP;
            M_GAP:   if (cnt_q == GAP_LAST) state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase

        // One counter serves every timed state; it restarts on each state change.
        if ((state_d == state_q) && (state_q != M_IDLE)) begin
            cnt_d = cnt_q + 4'd1;
        end

        // Outputs are registered from the next state so they line up with it.
        ss_n_d = (state_d == M_IDLE) || (state_d == M_GAP);
        if (accept) begin
            mosi_d = cmd_op[1];
        end else if (shift_out) begin
            mosi_d = tx_bit;
        end
        resp_valid_d = (state_q == M_RECV) && (state_d == M_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= M_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 2'b00;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            SS_n       <= ss_n_d;
            MOSI       <= mosi_d;
            cmd_ready  <= (state_d == M_IDLE);
            busy       <= (state_d != M_IDLE);
            resp_valid <= resp_valid_d;
            if (accept) begin
                op_q <= cmd_op;
            end
            if (resp_valid_d) begin
                resp_data <= rx_next;
            end
        end
    end

    a_ss_high_idle_gap: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == M_IDLE) || (state_q == M_GAP)) |-> SS_n);

    a_resp_after_recv: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (($past(state_q) == M_RECV) && (state_q == M_GAP)));

    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_ready |-> !busy);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - randomized self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

    localparam int TURN      = 2;
    localparam int GAP       = 1;
    localparam int SHORT_LEN = 11;
    localparam int LONG_LEN  = 19 + TURN;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [7:0] cmd_data  = 8'h00;
    logic       MISO      = 1'b0;
    logic       cmd_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;

    int errors = 0;
    int checks = 0;

    // wrapper/RAM slave model
    logic [7:0] mem [256];
    logic [7:0] waddr      = 8'h00;
    logic [7:0] raddr      = 8'h00;
    logic [7:0] reply_byte = 8'h00;

    // line monitor records
    bit          in_frame = 1'b0;
    int          cur_len  = 0;
    logic [31:0] cur_bits = '0;
    int          high_run = 0;
    int          frame_len_q  [$];
    logic [31:0] frame_bits_q [$];
    logic        frame_rv_q   [$];
    int          gap_q        [$];
    logic [7:0]  resp_q       [$];

    always #5 clk = ~clk;

    spi_master_ctrl #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .MISO       (MISO)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples the line mid-cycle and plays the slave: reply bits in the
    // receive window, random noise on MISO everywhere else.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) resp_q.push_back(resp_data);
            if (SS_n === 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_len  = 0;
                    cur_bits = '0;
                    gap_q.push_back(high_run);
                end
                cur_bits = {cur_bits[30:0], MOSI};
                cur_len++;
                if ((cur_len - 1 >= SHORT_LEN + TURN) && (cur_len - 1 < LONG_LEN))
                    MISO = reply_byte[7 - (cur_len - 1 - SHORT_LEN - TURN)];
                else
                    MISO = 1'($urandom_range(0, 1));
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    frame_len_q.push_back(cur_len);
                    frame_bits_q.push_back(cur_bits);
                    frame_rv_q.push_back(resp_valid);
                    high_run = 0;
                end
                high_run++;
                MISO = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic model_step(input logic [1:0] op, input logic [7:0] data,
                              output logic [9:0] w, output logic [7:0] exp_resp);
        w = {op, (op == 2'b11) ? 8'h00 : data};
        case (op)
            2'b00:   waddr = data;
            2'b01:   mem[waddr] = data;
            2'b10:   raddr = data;
            default: reply_byte = mem[raddr];
        endcase
        exp_resp = mem[raddr];
    endtask

    task automatic send(input int id, input logic [1:0] op, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("t%0d_ready", id), 32'(cmd_ready), 32'd1);
        resp_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic finish_txn(input int id, input logic [1:0] op, input logic [9:0] w,
                              input logic [7:0] exp_resp);
        int          n = 0;
        int          extra;
        int          got_len;
        logic [31:0] got_bits;
        logic        got_rv;
        logic [31:0] exp_bits;
        while (frame_len_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("t%0d_frame_seen", id), 32'(frame_len_q.size()), 32'd1);
        if (frame_len_q.size() == 0) return;
        repeat (2) @(negedge clk);
        check_eq($sformatf("t%0d_no_extra_frame", id), 32'(SS_n), 32'd1);
        got_len  = frame_len_q.pop_front();
        got_bits = frame_bits_q.pop_front();
        got_rv   = frame_rv_q.pop_front();
        extra    = (op == 2'b11) ? TURN + 8 : 0;
        exp_bits = {21'b0, w[9], w} << extra;
        check_eq($sformatf("t%0d_ss_low_len", id), 32'(got_len),
                 32'((op == 2'b11) ? LONG_LEN : SHORT_LEN));
        check_eq($sformatf("t%0d_mosi_bits", id), got_bits, exp_bits);
        check_eq($sformatf("t%0d_rv_first_gap", id), 32'(got_rv), 32'(op == 2'b11));
        check_eq($sformatf("t%0d_resp_count", id), 32'(resp_q.size()), 32'(op == 2'b11));
        if (op == 2'b11 && resp_q.size() != 0)
            check_eq($sformatf("t%0d_resp_data", id), 32'(resp_q[0]), 32'(exp_resp));
    endtask

    task automatic do_txn(input int id, input logic [1:0] op, input logic [7:0] data, input bit disturb);
        logic [9:0] w;
        logic [7:0] er;
        model_step(op, data, w, er);
        send(id, op, data);
        if (disturb) begin
            repeat (3) @(negedge clk);
            check_eq($sformatf("t%0d_busy_mid", id), 32'(busy), 32'd1);
            check_eq($sformatf("t%0d_ready_mid", id), 32'(cmd_ready), 32'd0);
            cmd_valid = 1'b1;
            cmd_op    = ~op;
            cmd_data  = ~data;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        finish_txn(id, op, w, er);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  b_op [3];
        logic [7:0]  b_d  [3];
        logic [9:0]  b_w  [3];
        logic [7:0]  er;
        logic [9:0]  w;
        int          n;
        int          lowcnt;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check_eq("rst_ss_n", 32'(SS_n), 32'd1);
        check_eq("rst_mosi", 32'(MOSI), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_data", 32'(resp_data), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        do_txn(1, 2'b00, 8'h2A, 1'b0);
        do_txn(2, 2'b00, 8'h40, 1'b0);
        do_txn(3, 2'b01, 8'hA5, 1'b0);
        do_txn(4, 2'b10, 8'h40, 1'b0);
        do_txn(5, 2'b11, 8'h00, 1'b0);
        check_eq("rd_a5_value", 32'(resp_data), 32'hA5);
        do_txn(6, 2'b00, 8'h10, 1'b0);
        do_txn(7, 2'b01, 8'h5C, 1'b0);
        do_txn(8, 2'b10, 8'h10, 1'b0);
        do_txn(9, 2'b11, 8'hFF, 1'b0);
        check_eq("rd_5c_value", 32'(resp_data), 32'h5C);
        do_txn(10, 2'b01, 8'h77, 1'b1);

        // back-to-back with cmd_valid held high
        gap_q.delete();
        resp_q.delete();
        for (int k = 0; k < 3; k++) begin
            b_op[k] = 2'(k);
            b_d[k]  = 8'($urandom);
            model_step(b_op[k], b_d[k], b_w[k], er);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_op   = b_op[k];
            cmd_data = b_d[k];
            n = 0;
            while (cmd_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (frame_len_q.size() < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check_eq("b2b_frame_count", 32'(frame_len_q.size()), 32'd3);
        if (frame_len_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check_eq($sformatf("b2b%0d_len", k), 32'(frame_len_q[k]), 32'(SHORT_LEN));
                check_eq($sformatf("b2b%0d_bits", k), frame_bits_q[k], {21'b0, b_w[k][9], b_w[k]});
            end
        end
        if (gap_q.size() >= 3) begin
            check_eq("b2b_gap1", 32'(gap_q[1]), 32'(GAP + 1));
            check_eq("b2b_gap2", 32'(gap_q[2]), 32'(GAP + 1));
        end else begin
            check_eq("b2b_gap_count", 32'(gap_q.size()), 32'd3);
        end
        check_eq("b2b_no_resp", 32'(resp_q.size()), 32'd0);
        frame_len_q.delete();
        frame_bits_q.delete();
        frame_rv_q.delete();

        // reset during SHIFT bit 5
        send(100, 2'b00, 8'hC3);
        lowcnt = 0;
        n = 0;
        while (lowcnt < 7 && n < 50) begin
            @(negedge clk);
            if (SS_n === 1'b0) lowcnt++;
            n++;
        end
        check_eq("rst_mid_reach", 32'(lowcnt), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ss_n", 32'(SS_n), 32'd1);
        check_eq("rst_mid_mosi", 32'(MOSI), 32'd0);
        check_eq("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_mid_trunc_frames", 32'(frame_len_q.size()), 32'd1);
        if (frame_len_q.size() != 0) begin
            check_eq("rst_mid_trunc_len", 32'(frame_len_q.pop_front()), 32'd7);
            void'(frame_bits_q.pop_front());
            void'(frame_rv_q.pop_front());
        end
        check_eq("rst_mid_no_resp", 32'(resp_q.size()), 32'd0);
        model_step(2'b00, 8'h5A, w, er);
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 8'h5A;
        resp_q.delete();
        @(posedge clk);
        #1;
        check_eq("rst_first_edge_accept", 32'(SS_n), 32'd0);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        finish_txn(101, 2'b00, w, er);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            do_txn(200 + i, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
